// File: rtl/ysyx_23060061_axil_pkg.sv
// Shared constants and FSM state types for the AXI-Lite SRAM model.
package ysyx_23060061_axil_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/ysyx_23060061_lfsr16.sv
// 16-bit Fibonacci LFSR used as the source of pseudo-random response latency.
module ysyx_23060061_lfsr16
    import ysyx_23060061_axil_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] lfsr_state
);

    logic [15:0] state_reg;
    logic [15:0] state_next;

    always_comb begin
        state_next = state_reg;
        if (en) begin
            state_next = {state_reg[14:0], ^(state_reg & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= SEED;
        end else begin
            state_reg <= state_next;
        end
    end

    assign lfsr_state = state_reg;

endmodule

// File: rtl/ysyx_23060061_axil_sram_param.sv
// AXI-Lite slave memory: word-addressed array behind independent read and
// write FSMs, each with a fixed or LFSR-driven response latency.
module ysyx_23060061_axil_sram_param
    import ysyx_23060061_axil_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                LAT_MODE  = 0,
    parameter int                FIXED_LAT = 1,
    parameter int                LAT_BITS  = 4,
    parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int          STRB_W   = DATA_W / 8;
    localparam int          OFF_BITS = $clog2(STRB_W);
    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [15:0] LAT_MASK = 16'((32'd1 << LAT_BITS) - 32'd1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [15:0] lfsr_state;

    ysyx_23060061_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .en         (1'b1),
        .lfsr_state (lfsr_state)
    );

    // Read channel state
    rd_state_e         rd_state_reg, rd_state_next;
    logic [7:0]        rd_cnt_reg, rd_cnt_next;
    logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
    logic              arready_reg, arready_next;
    logic              rvalid_reg, rvalid_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic [1:0]        rresp_reg, rresp_next;

    // Write channel state
    wr_state_e         wr_state_reg, wr_state_next;
    logic [7:0]        wr_cnt_reg, wr_cnt_next;
    logic [ADDR_W-1:0] awaddr_reg, awaddr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [STRB_W-1:0] wstrb_reg, wstrb_next;
    logic              awready_reg, awready_next;
    logic              wready_reg, wready_next;
    logic              bvalid_reg, bvalid_next;
    logic [1:0]        bresp_reg, bresp_next;

    logic              ar_hs, aw_hs, w_hs, wr_accept;
    logic              rd_fire, wr_fire, wr_en;
    logic [7:0]        rd_lat, wr_lat;
    logic [15:0]       wr_lat_src;
    logic [ADDR_W-1:0] rd_addr_eff, wr_addr_eff;
    logic [ADDR_W-1:0] rd_word_full, wr_word_full;
    logic              rd_bad, wr_bad;
    logic [IDX_W-1:0]  rd_idx, wr_idx;
    logic [DATA_W-1:0] wdata_eff;
    logic [STRB_W-1:0] wstrb_eff;
    logic [DATA_W-1:0] rd_word, rd_merge;

    assign ar_hs     = arvalid && arready_reg;
    assign aw_hs     = awvalid && awready_reg;
    assign w_hs      = wvalid && wready_reg;
    // A dropped ready means that half of the write is already held.
    assign wr_accept = (wr_state_reg == W_IDLE) && (aw_hs || !awready_reg)
                       && (w_hs || !wready_reg);

    // When both channels accept together the write sees a rotated sample.
    assign wr_lat_src = ar_hs ? {lfsr_state[7:0], lfsr_state[15:8]} : lfsr_state;
    assign rd_lat = (LAT_MODE != 0) ? 8'(lfsr_state & LAT_MASK) : 8'(FIXED_LAT);
    assign wr_lat = (LAT_MODE != 0) ? 8'(wr_lat_src & LAT_MASK) : 8'(FIXED_LAT);

    assign rd_addr_eff = (rd_state_reg == R_IDLE) ? araddr : rd_addr_reg;
    assign wr_addr_eff = awready_reg ? awaddr : awaddr_reg;
    assign wdata_eff   = wready_reg ? wdata : wdata_reg;
    assign wstrb_eff   = wready_reg ? wstrb : wstrb_reg;

    assign rd_word_full = (rd_addr_eff - BASE_ADDR) >> OFF_BITS;
    assign wr_word_full = (wr_addr_eff - BASE_ADDR) >> OFF_BITS;
    assign rd_bad = (rd_addr_eff < BASE_ADDR) || (rd_word_full >= ADDR_W'(DEPTH));
    assign wr_bad = (wr_addr_eff < BASE_ADDR) || (wr_word_full >= ADDR_W'(DEPTH));
    assign rd_idx = rd_word_full[IDX_W-1:0];
    assign wr_idx = wr_word_full[IDX_W-1:0];

    // Zero latency completes on the accepting edge itself.
    assign rd_fire = ((rd_state_reg == R_IDLE) && ar_hs && (rd_lat == 8'd0))
                     || ((rd_state_reg == R_WAIT) && (rd_cnt_reg == 8'd0));
    assign wr_fire = (wr_accept && (wr_lat == 8'd0))
                     || ((wr_state_reg == W_WAIT) && (wr_cnt_reg == 8'd0));
    assign wr_en   = wr_fire && !wr_bad && rst;

    assign rd_word = mem[rd_idx];

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        assign rd_merge[gi*8 +: 8] = (wr_en && wstrb_eff[gi] && (wr_idx == rd_idx))
                                     ? wdata_eff[gi*8 +: 8] : rd_word[gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_eff[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wdata_eff[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        rd_cnt_next   = rd_cnt_reg;
        rd_addr_next  = rd_addr_reg;
        arready_next  = arready_reg;
        rvalid_next   = rvalid_reg;
        rdata_next    = rdata_reg;
        rresp_next    = rresp_reg;
        case (rd_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    arready_next  = 1'b0;
                    rd_addr_next  = araddr;
                    rd_cnt_next   = (rd_lat == 8'd0) ? 8'd0 : rd_lat - 8'd1;
                    rd_state_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_reg != 8'd0) begin
                    rd_cnt_next = rd_cnt_reg - 8'd1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_next   = 1'b0;
                    arready_next  = 1'b1;
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
        if (rd_fire) begin
            rvalid_next   = 1'b1;
            rdata_next    = rd_bad ? '0 : rd_merge;
            rresp_next    = rd_bad ? RESP_SLVERR : RESP_OKAY;
            rd_state_next = R_RESP;
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        wr_cnt_next   = wr_cnt_reg;
        awaddr_next   = awaddr_reg;
        wdata_next    = wdata_reg;
        wstrb_next    = wstrb_reg;
        awready_next  = awready_reg;
        wready_next   = wready_reg;
        bvalid_next   = bvalid_reg;
        bresp_next    = bresp_reg;
        case (wr_state_reg)
            W_IDLE: begin
                if (aw_hs) begin
                    awready_next = 1'b0;
                    awaddr_next  = awaddr;
                end
                if (w_hs) begin
                    wready_next = 1'b0;
                    wdata_next  = wdata;
                    wstrb_next  = wstrb;
                end
                if (wr_accept) begin
                    wr_cnt_next   = (wr_lat == 8'd0) ? 8'd0 : wr_lat - 8'd1;
                    wr_state_next = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_cnt_reg != 8'd0) begin
                    wr_cnt_next = wr_cnt_reg - 8'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_next   = 1'b0;
                    awready_next  = 1'b1;
                    wready_next   = 1'b1;
                    wr_state_next = W_IDLE;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
        if (wr_fire) begin
            bvalid_next   = 1'b1;
            bresp_next    = wr_bad ? RESP_SLVERR : RESP_OKAY;
            wr_state_next = W_RESP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_reg <= R_IDLE;
            rd_cnt_reg   <= 8'd0;
            rd_addr_reg  <= '0;
            arready_reg  <= 1'b1;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
            wr_state_reg <= W_IDLE;
            wr_cnt_reg   <= 8'd0;
            awaddr_reg   <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            awready_reg  <= 1'b1;
            wready_reg   <= 1'b1;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            rd_state_reg <= rd_state_next;
            rd_cnt_reg   <= rd_cnt_next;
            rd_addr_reg  <= rd_addr_next;
            arready_reg  <= arready_next;
            rvalid_reg   <= rvalid_next;
            rdata_reg    <= rdata_next;
            rresp_reg    <= rresp_next;
            wr_state_reg <= wr_state_next;
            wr_cnt_reg   <= wr_cnt_next;
            awaddr_reg   <= awaddr_next;
            wdata_reg    <= wdata_next;
            wstrb_reg    <= wstrb_next;
            awready_reg  <= awready_next;
            wready_reg   <= wready_next;
            bvalid_reg   <= bvalid_next;
            bresp_reg    <= bresp_next;
        end
    end

    assign arready = arready_reg;
    assign rvalid  = rvalid_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;
    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;

endmodule
